// File: rtl/demux_buffered_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_buffered_pkg
// Description : Shared width helper and power-of-two check used by the
//               buffered demultiplexer and its channel FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_buffered_pkg;

    // Index width for n entries; never below 1 so 1-entry cases still get a bit.
    function automatic int clog2w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // True when n is a positive power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_fifo_channel.sv
`default_nettype none
// ============================================================================
// Module      : demux_fifo_channel
// Description : Single-clock FIFO for one demux output channel. The read
//               port shows the head word, or zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_fifo_channel
    import demux_buffered_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int             PW     = clog2w(DEPTH);
    localparam logic [PW:0]    C_FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == C_FULL);
    assign empty = (r_count == '0);

    // Guard locally as well, so a careless caller can never over/underflow.
    assign w_push = wr_en & ~full;
    assign w_pop  = rd_en & ~empty;

    // Empty channel drives zero instead of a stale head word.
    assign rd_data = empty ? '0 : r_mem[r_rptr];

    // Pointer and occupancy bookkeeping; reset and flush both discard contents.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux_buffered
// Description : 1:N demultiplexer with a small FIFO per output channel and
//               valid/ready handshakes on both sides. in_ready depends only
//               on in_sel and registered occupancy, never on out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_buffered
    import demux_buffered_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [$clog2(CHANNELS)-1:0]   in_sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [CHANNELS*WIDTH-1:0]     out_bus,
    output logic [CHANNELS-1:0]           out_valid,
    input  logic [CHANNELS-1:0]           out_ready,
    input  logic                          flush
);

    localparam int SW = $clog2(CHANNELS);

    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_wr_en;

    // Elaboration-time sanity check on the geometry.
    if (!is_pow2(CHANNELS) || CHANNELS < 2 || !is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_geometry
        $error("demux_buffered: CHANNELS and DEPTH must be powers of 2 and >= 2");
    end

    assign in_ready = ~w_full[in_sel];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [SW-1:0] C_IDX = SW'(g);

        // One-hot write enable: only the selected channel sees the accept.
        assign w_wr_en[g]   = in_valid & in_ready & (in_sel == C_IDX);
        assign out_valid[g] = ~w_empty[g];

        demux_fifo_channel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .wr_en   (w_wr_en[g]),
            .wr_data (in_data),
            .full    (w_full[g]),
            .rd_en   (out_ready[g]),
            .rd_data (out_bus[g*WIDTH +: WIDTH]),
            .empty   (w_empty[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_buffered
// Description : Directed, table-driven bench for demux_buffered with
//               CHANNELS=4, DEPTH=2, WIDTH=64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_buffered;

    localparam int WIDTH    = 64;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [WIDTH-1:0]          in_data;
    logic [1:0]                in_sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] out_bus;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic                      flush;

    int errors = 0;
    int checks = 0;

    demux_buffered #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bus   (out_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // Occupancy must never exceed DEPTH on any channel.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_mon
        always @(negedge clk) begin
            if (dut.g_ch[g].u_fifo.r_count > 2'(DEPTH)) begin
                $display("FAIL count_overflow ch%0d: count=%0d limit=%0d",
                         g, dut.g_ch[g].u_fifo.r_count, DEPTH);
                errors++;
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        flush;
        logic        vld;
        logic [1:0]  sel;
        logic [63:0] data;
        logic [3:0]  ordy;
        logic        erdy;
        logic [3:0]  evld;
        logic [255:0] ebus;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [255:0] bus(input logic [63:0] h0, input logic [63:0] h1,
                                         input logic [63:0] h2, input logic [63:0] h3);
        return {h3, h2, h1, h0};
    endfunction

    task automatic add(input logic r, input logic f, input logic v, input logic [1:0] s,
                       input logic [63:0] d, input logic [3:0] ordy, input logic erdy,
                       input logic [3:0] evld, input logic [255:0] ebus);
        vec_t t;
        t.rst = r; t.flush = f; t.vld = v; t.sel = s; t.data = d;
        t.ordy = ordy; t.erdy = erdy; t.evld = evld; t.ebus = ebus;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        in_data = 64'hDEAD_BEEF; out_ready = '0;

        // ---- Reset state: two cycles of rst with in_valid held high ----
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_out_bus", out_bus, 256'(0));
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int s = 0; s < CHANNELS; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("reset_in_ready_sel%0d", s), 256'(in_ready), 256'(1));
        end

        // ---- Single route, one-cycle latency ----
        add(0,0,1,2,64'hA5,4'b0000,1,4'b0100,bus(0,0,64'hA5,0));
        add(0,0,0,0,64'h0, 4'b0100,1,4'b0000,bus(0,0,0,0));

        // ---- Backpressure and fill on ch1 ----
        add(0,0,1,1,64'h11,4'b0000,1,4'b0010,bus(0,64'h11,0,0));
        add(0,0,1,1,64'h22,4'b0000,1,4'b0010,bus(0,64'h11,0,0));
        add(0,0,1,1,64'h33,4'b0000,0,4'b0010,bus(0,64'h11,0,0));
        add(0,0,0,0,64'h33,4'b0000,1,4'b0010,bus(0,64'h11,0,0));
        add(0,0,0,1,64'h0, 4'b0010,0,4'b0010,bus(0,64'h22,0,0));
        add(0,0,0,1,64'h0, 4'b0000,1,4'b0010,bus(0,64'h22,0,0));
        add(0,0,0,1,64'h0, 4'b0010,1,4'b0000,bus(0,0,0,0));

        // ---- Concurrent accept and dequeue when full on ch0 ----
        add(0,0,1,0,64'h1,4'b0000,1,4'b0001,bus(64'h1,0,0,0));
        add(0,0,1,0,64'h2,4'b0000,1,4'b0001,bus(64'h1,0,0,0));
        add(0,0,1,0,64'h3,4'b0001,0,4'b0001,bus(64'h2,0,0,0));
        add(0,0,1,0,64'h3,4'b0000,1,4'b0001,bus(64'h2,0,0,0));
        add(0,0,0,0,64'h0,4'b0001,0,4'b0001,bus(64'h3,0,0,0));
        add(0,0,0,0,64'h0,4'b0001,1,4'b0000,bus(0,0,0,0));

        // ---- Wrap-around streaming on ch3 ----
        for (int k = 0; k < 10; k++) begin
            w = 64'hF000_0000_0000_0000 | 64'(k);
            add(0,0,1,3,w,4'b1000,1,4'b1000,bus(0,0,0,w));
        end
        add(0,0,0,3,64'h0,4'b1000,1,4'b0000,bus(0,0,0,0));

        // ---- Parallel dequeue and out_ready on empty channels ----
        add(0,0,1,0,64'h5,4'b0000,1,4'b0001,bus(64'h5,0,0,0));
        add(0,0,1,1,64'h6,4'b0000,1,4'b0011,bus(64'h5,64'h6,0,0));
        add(0,0,0,0,64'h0,4'b0011,1,4'b0000,bus(0,0,0,0));
        add(0,0,1,1,64'h7,4'b1111,1,4'b0010,bus(0,64'h7,0,0));
        add(0,0,0,1,64'h0,4'b0000,1,4'b0010,bus(0,64'h7,0,0));
        add(0,0,0,1,64'h0,4'b0010,1,4'b0000,bus(0,0,0,0));

        // ---- Flush mid-stream ----
        add(0,0,1,0,64'hAA,4'b0000,1,4'b0001,bus(64'hAA,0,0,0));
        add(0,0,1,0,64'hBB,4'b0000,1,4'b0001,bus(64'hAA,0,0,0));
        add(0,0,1,2,64'hCC,4'b0000,1,4'b0101,bus(64'hAA,0,64'hCC,0));
        add(0,1,1,2,64'hDD,4'b0000,1,4'b0000,bus(0,0,0,0));
        add(0,0,0,2,64'h0, 4'b0000,1,4'b0000,bus(0,0,0,0));

        // ---- Reset mid-stream ----
        add(0,0,1,0,64'hAA,4'b0000,1,4'b0001,bus(64'hAA,0,0,0));
        add(0,0,1,0,64'hBB,4'b0000,1,4'b0001,bus(64'hAA,0,0,0));
        add(0,0,1,2,64'hCC,4'b0000,1,4'b0101,bus(64'hAA,0,64'hCC,0));
        add(1,0,1,2,64'hDD,4'b0000,1,4'b0000,bus(0,0,0,0));
        add(0,0,0,2,64'h0, 4'b0000,1,4'b0000,bus(0,0,0,0));

        // Apply each vector: in_ready checked before the edge, outputs after it.
        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].vld;
            in_sel = tbl[i].sel; in_data = tbl[i].data; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 256'(in_ready), 256'(tbl[i].erdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 256'(out_valid), 256'(tbl[i].evld));
            chk($sformatf("v%0d_out_bus", i), out_bus, tbl[i].ebus);
        end

        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = '0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
